// File: rtl/serial_sub_32.sv
// Bit-serial two's-complement subtractor: y = a - b, one bit per clock, LSB first.
// Results and flags load at completion and hold until the next operation finishes.
module serial_sub_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             borrow,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] sa_r, sb_r, sr_r, y_r;
  logic [CW-1:0]    cnt_r;
  logic             br_r, a_msb_r, b_msb_r;
  logic             borrow_r, zero_r, ovf_r, busy_r, done_r;
  logic             accept_s, last_s, d_s, br_next_s;
  logic [WIDTH-1:0] y_next_s;

  // Next-state decode; start is honoured only from IDLE or DONE
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_BIT) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      default: begin
        state_s  = IDLE;
        accept_s = 1'b0;
      end
    endcase
  end

  // One full-subtractor bit slice plus the shifted-in result word
  always_comb begin
    d_s       = sa_r[0] ^ sb_r[0] ^ br_r;
    br_next_s = (~sa_r[0] & sb_r[0]) | (~(sa_r[0] ^ sb_r[0]) & br_r);
    y_next_s  = {d_s, sr_r[WIDTH-1:1]};
    last_s    = (state_r == RUN) && (cnt_r == LAST_BIT);
  end

  // State, operand shifters, and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      sa_r     <= {WIDTH{1'b0}};
      sb_r     <= {WIDTH{1'b0}};
      sr_r     <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      br_r     <= 1'b0;
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      y_r      <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
      if (accept_s) begin
        sa_r    <= a;
        sb_r    <= b;
        a_msb_r <= a[WIDTH-1];
        b_msb_r <= b[WIDTH-1];
        br_r    <= 1'b0;
        cnt_r   <= {CW{1'b0}};
        sr_r    <= {WIDTH{1'b0}};
      end else if (state_r == RUN) begin
        sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
        sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
        br_r  <= br_next_s;
        cnt_r <= cnt_r + CW'(1);
        sr_r  <= y_next_s;
      end
      // Signed overflow: operands differ in sign and the result sign departs from a
      if (last_s) begin
        y_r      <= y_next_s;
        borrow_r <= br_next_s;
        zero_r   <= (y_next_s == {WIDTH{1'b0}});
        ovf_r    <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign y      = y_r;
  assign borrow = borrow_r;
  assign zero   = zero_r;
  assign ovf    = ovf_r;

endmodule

// File: tb/tb_serial_sub_32.sv
// Self-checking bench for serial_sub_32: directed vectors, start/reset handling,
// back-to-back throughput and randomized operands against an arithmetic model.
module tb_serial_sub_32;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] y;
  logic         borrow, zero, ovf;

  int checks;
  int errors;

  serial_sub_32 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .y(y), .borrow(borrow), .zero(zero), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, zero, borrow, y} from plain modular arithmetic
  function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    logic [W-1:0] dif;
    logic         bw, zr, ov;
    dif = ma - mb;
    bw  = (ma < mb);
    zr  = (dif == 0);
    ov  = (ma[W-1] != mb[W-1]) && (dif[W-1] != ma[W-1]);
    return {ov, zr, bw, dif};
  endfunction

  // Issue one operation and wait (bounded) for done; sampled on negedges
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        output int cyc, output int busy_cnt, output bit timed_out,
                        output bit overlap);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;
    cyc = 0; busy_cnt = 0; timed_out = 1'b0; overlap = 1'b0;
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      if (busy && done) overlap = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (busy && done) overlap = 1'b1;
    timed_out = !done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, y, borrow, zero, ovf} !== {(W+5){1'b0}}) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b y=%h bw=%b z=%b ov=%b expected all 0",
               busy, done, y, borrow, zero, ovf);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [5] = '{32'd5, 32'd3, 32'h8000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
    logic [W-1:0] tb [5] = '{32'd3, 32'd5, 32'd1, 32'h8765_4321, 32'hDEAD_BEEF};
    logic [W-1:0] ty [5] = '{32'h2, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8ACF_1357, 32'h0};
    logic [2:0]   tf [5] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010}; // {ovf, zero, borrow}
    int cyc, bc;
    bit to, ovl;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], cyc, bc, to, ovl);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL directed_timeout vec=%0d no done within 100 cycles", i);
      end
      checks++;
      if (cyc !== W) begin
        errors++;
        $display("FAIL directed_latency vec=%0d got %0d expected %0d", i, cyc, W);
      end
      checks++;
      if (bc !== W) begin
        errors++;
        $display("FAIL directed_busy_cycles vec=%0d got %0d expected %0d", i, bc, W);
      end
      checks++;
      if (ovl) begin
        errors++;
        $display("FAIL directed_busy_done_overlap vec=%0d got 1 expected 0", i);
      end
      checks++;
      if (y !== ty[i] || {ovf, zero, borrow} !== tf[i]) begin
        errors++;
        $display("FAIL directed_result vec=%0d got y=%h f=%b expected y=%h f=%b",
                 i, y, {ovf, zero, borrow}, ty[i], tf[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || y !== ty[i]) begin
        errors++;
        $display("FAIL directed_done_pulse vec=%0d got done=%b y=%h expected done=0 y=%h",
                 i, done, y, ty[i]);
      end
    end
  endtask

  task automatic test_start_ignored;
    logic [W-1:0] a1, b1, got_y;
    logic [W+2:0] exp;
    int ndone;
    a1 = $urandom; b1 = $urandom;
    exp = model(a1, b1);
    @(negedge clk);
    a = a1; b = b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; got_y = '0;
    for (int c = 1; c < 80; c++) begin
      if (c == 7 || c == 20) begin
        a = ~a1; b = a1 ^ 32'h5A5A_5A5A; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        ndone++;
        got_y = y;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL start_ignored_done_count got %0d expected 1", ndone);
    end
    checks++;
    if (got_y !== exp[W-1:0]) begin
      errors++;
      $display("FAIL start_ignored_result got %h expected %h", got_y, exp[W-1:0]);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [W+2:0] exp;
    int ndone, cyc, bc;
    bit to, ovl;
    @(negedge clk);
    a = 32'h0000_0010; b = 32'h0000_0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, y, borrow, zero, ovf} !== {(W+5){1'b0}}) begin
      errors++;
      $display("FAIL reset_mid_run_outputs got busy=%b done=%b y=%h bw=%b z=%b ov=%b expected all 0",
               busy, done, y, borrow, zero, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_mid_run_no_done got %0d active cycles expected 0", ndone);
    end
    run_op(32'h0000_0100, 32'h0000_0200, cyc, bc, to, ovl);
    exp = model(32'h0000_0100, 32'h0000_0200);
    checks++;
    if (to || y !== exp[W-1:0] || {ovf, zero, borrow} !== exp[W+2:W]) begin
      errors++;
      $display("FAIL reset_mid_run_restart got to=%b y=%h f=%b expected y=%h f=%b",
               to, y, {ovf, zero, borrow}, exp[W-1:0], exp[W+2:W]);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a1, b1, a2, b2;
    logic [W+2:0] e1, e2;
    int cyc, bc, gap;
    bit to, ovl, held_ok;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    e1 = model(a1, b1);
    e2 = model(a2, b2);
    run_op(a1, b1, cyc, bc, to, ovl);
    a = a2; b = b2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gap = 1; held_ok = 1'b1;
    while (!done && gap < 100) begin
      if (y !== e1[W-1:0]) held_ok = 1'b0;
      @(negedge clk);
      gap++;
    end
    checks++;
    if (gap !== W + 1) begin
      errors++;
      $display("FAIL back_to_back_interval got %0d expected %0d", gap, W + 1);
    end
    checks++;
    if (!held_ok) begin
      errors++;
      $display("FAIL back_to_back_hold got y changed before done expected %h held", e1[W-1:0]);
    end
    checks++;
    if (y !== e2[W-1:0] || {ovf, zero, borrow} !== e2[W+2:W]) begin
      errors++;
      $display("FAIL back_to_back_result got y=%h f=%b expected y=%h f=%b",
               y, {ovf, zero, borrow}, e2[W-1:0], e2[W+2:W]);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] ra, rb;
    logic [W+2:0] exp;
    int cyc, bc;
    bit to, ovl;
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = (n % 16 == 0) ? ra : W'($urandom);
      exp = model(ra, rb);
      run_op(ra, rb, cyc, bc, to, ovl);
      checks++;
      if (to || y !== exp[W-1:0] || {ovf, zero, borrow} !== exp[W+2:W]) begin
        errors++;
        $display("FAIL random n=%0d a=%h b=%h got to=%b y=%h f=%b expected y=%h f=%b",
                 n, ra, rb, to, y, {ovf, zero, borrow}, exp[W-1:0], exp[W+2:W]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_directed;
    test_start_ignored;
    test_reset_mid_run;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
